// File: rtl/sdio_crc16_rx_check.sv
// sdio_crc16_rx_check: receive-side CRC16 (x^16+x^12+x^5+1, init 0, MSB first)
// checker for one SDIO DAT lane. Waits for the start bit, runs the CRC over the
// payload, captures the card CRC, checks the end bit and reports the outcome.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | not armed; waits for start_i
// ST_WAIT    | armed; waits for the start bit (0), counts idle strobes
// ST_DATA    | payload bits, CRC updated per strobe, bits forwarded
// ST_CRC     | 16 card CRC bits shifted into crc_rcvd
// ST_END     | end bit; flags and done_o are produced on this strobe
module sdio_crc16_rx_check #(
  parameter int LEN_W = 13,
  parameter int TO_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic             abort_i,
  input  logic             sample_i,
  input  logic             data_i,
  output logic             busy_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             done_o,
  output logic             crc_err_o,
  output logic             end_err_o,
  output logic             timeout_o,
  output logic [15:0]      crc_calc_o,
  output logic [15:0]      crc_rcvd_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CRC  = 3'd3;
  localparam logic [2:0] ST_END  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;
  logic [15:0]      crc_calc_q, crc_calc_d;
  logic [15:0]      crc_rcvd_q, crc_rcvd_d;
  logic             bit_q, bit_d;
  logic             bit_valid_q, bit_valid_d;
  logic             done_q, done_d;
  logic             crc_err_q, crc_err_d;
  logic             end_err_q, end_err_d;
  logic             timeout_err_q, timeout_err_d;

  // One wider than the counters so the terminal compare cannot alias on wrap.
  logic [TO_W:0]    to_cnt_inc;
  logic [LEN_W:0]   bit_cnt_inc;
  logic             fb;

  assign to_cnt_inc  = {1'b0, to_cnt_q} + {{TO_W{1'b0}}, 1'b1};
  assign bit_cnt_inc = {1'b0, bit_cnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign fb          = data_i ^ crc_calc_q[15];

  // Next-state logic: abort beats start/sample; FSM advances on sample strobes.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    timeout_d     = timeout_q;
    to_cnt_d      = to_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    crc_cnt_d     = crc_cnt_q;
    crc_calc_d    = crc_calc_q;
    crc_rcvd_d    = crc_rcvd_q;
    bit_d         = bit_q;
    bit_valid_d   = 1'b0;
    done_d        = 1'b0;
    crc_err_d     = crc_err_q;
    end_err_d     = end_err_q;
    timeout_err_d = timeout_err_q;

    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_d         = len_i;
            timeout_d     = timeout_i;
            to_cnt_d      = '0;
            bit_cnt_d     = '0;
            crc_cnt_d     = '0;
            crc_calc_d    = '0;
            crc_rcvd_d    = '0;
            crc_err_d     = 1'b0;
            end_err_d     = 1'b0;
            timeout_err_d = 1'b0;
            state_d       = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sample_i) begin
            if (!data_i) begin
              state_d = (len_q == '0) ? ST_CRC : ST_DATA;
            end else begin
              // Saturate so an unlimited wait (timeout 0) never wraps.
              if (to_cnt_q != '1) to_cnt_d = to_cnt_inc[TO_W-1:0];
              if ((timeout_q != '0) && (to_cnt_inc == {1'b0, timeout_q})) begin
                timeout_err_d = 1'b1;
                done_d        = 1'b1;
                state_d       = ST_IDLE;
              end
            end
          end
        end
        ST_DATA: begin
          if (sample_i) begin
            crc_calc_d  = {crc_calc_q[14:12], crc_calc_q[11] ^ fb, crc_calc_q[10:5],
                           crc_calc_q[4] ^ fb, crc_calc_q[3:0], fb};
            bit_d       = data_i;
            bit_valid_d = 1'b1;
            bit_cnt_d   = bit_cnt_inc[LEN_W-1:0];
            if (bit_cnt_inc == {1'b0, len_q}) state_d = ST_CRC;
          end
        end
        ST_CRC: begin
          if (sample_i) begin
            crc_rcvd_d = {crc_rcvd_q[14:0], data_i};
            if (crc_cnt_q == 4'd15) begin
              state_d = ST_END;
            end else begin
              crc_cnt_d = crc_cnt_q + 4'd1;
            end
          end
        end
        ST_END: begin
          if (sample_i) begin
            end_err_d = ~data_i;
            crc_err_d = (crc_rcvd_q != crc_calc_q);
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      timeout_q     <= '0;
      to_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      crc_cnt_q     <= '0;
      crc_calc_q    <= '0;
      crc_rcvd_q    <= '0;
      bit_q         <= 1'b0;
      bit_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      crc_err_q     <= 1'b0;
      end_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      timeout_q     <= timeout_d;
      to_cnt_q      <= to_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      crc_cnt_q     <= crc_cnt_d;
      crc_calc_q    <= crc_calc_d;
      crc_rcvd_q    <= crc_rcvd_d;
      bit_q         <= bit_d;
      bit_valid_q   <= bit_valid_d;
      done_q        <= done_d;
      crc_err_q     <= crc_err_d;
      end_err_q     <= end_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign bit_o       = bit_q;
  assign bit_valid_o = bit_valid_q;
  assign done_o      = done_q;
  assign crc_err_o   = crc_err_q;
  assign end_err_o   = end_err_q;
  assign timeout_o   = timeout_err_q;
  assign crc_calc_o  = crc_calc_q;
  assign crc_rcvd_o  = crc_rcvd_q;

endmodule

// File: tb/tb_sdio_crc16_rx_check.sv
// Testbench for sdio_crc16_rx_check: directed blocks, expected results queued
// by the stimulus and checked by a monitor whenever done_o / bit_valid_o fire.
module tb_sdio_crc16_rx_check;

  localparam int LEN_W = 13;
  localparam int TO_W  = 16;

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic [TO_W-1:0]  timeout_i;
  logic             abort_i;
  logic             sample_i;
  logic             data_i;
  logic             busy_o;
  logic             bit_o;
  logic             bit_valid_o;
  logic             done_o;
  logic             crc_err_o;
  logic             end_err_o;
  logic             timeout_o;
  logic [15:0]      crc_calc_o;
  logic [15:0]      crc_rcvd_o;

  sdio_crc16_rx_check #(.LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .timeout_i  (timeout_i),
    .abort_i    (abort_i),
    .sample_i   (sample_i),
    .data_i     (data_i),
    .busy_o     (busy_o),
    .bit_o      (bit_o),
    .bit_valid_o(bit_valid_o),
    .done_o     (done_o),
    .crc_err_o  (crc_err_o),
    .end_err_o  (end_err_o),
    .timeout_o  (timeout_o),
    .crc_calc_o (crc_calc_o),
    .crc_rcvd_o (crc_rcvd_o)
  );

  typedef struct {
    logic [15:0] calc;
    logic [15:0] rcvd;
    logic        cerr;
    logic        eerr;
    logic        to;
    int          nbits;
  } exp_t;

  exp_t exp_q[$];
  logic exp_bits[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   bv_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    sample_i = 1'b1;
    data_i   = b;
    tick();
    sample_i = 1'b0;
    repeat (gap) tick();
  endtask

  // One block: start pulse, an idle 1, start bit, payload (repeating pat,
  // MSB first), card CRC, end bit. abort_after >= 0 aborts before that bit.
  task automatic run_block(input int len, input logic [7:0] pat, input logic [15:0] card_crc,
                           input logic end_bit, input int gap, input logic [15:0] exp_calc,
                           input logic exp_cerr, input int abort_after, input bit mid_start);
    exp_t e;
    logic b;
    e.calc  = exp_calc;
    e.rcvd  = card_crc;
    e.cerr  = exp_cerr;
    e.eerr  = ~end_bit;
    e.to    = 1'b0;
    e.nbits = len;
    if (abort_after < 0) exp_q.push_back(e);
    len_i     = len[LEN_W-1:0];
    timeout_i = '0;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    strobe(1'b1, gap);
    strobe(1'b0, gap);
    for (int i = 0; i < len; i++) begin
      b = pat[7 - (i % 8)];
      if (i == abort_after) begin
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_busy_low", 32'(busy_o), 32'd0);
        return;
      end
      exp_bits.push_back(b);
      if (mid_start && i == 4) begin
        start_i = 1'b1;
        len_i   = 13'd3;
      end
      strobe(b, gap);
      start_i = 1'b0;
    end
    for (int i = 0; i < 16; i++) strobe(card_crc[15 - i], gap);
    strobe(end_bit, gap);
    repeat (3) tick();
  endtask

  // Monitor: checks forwarded payload bits and the block result on done_o.
  initial begin
    exp_t e;
    logic eb;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (start_i && !busy_o && !abort_i) bv_cnt = 0;
        if (bit_valid_o) begin
          bv_cnt++;
          if (exp_bits.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_bit_valid: got bit_valid_o=1 expected none at %0t", $time);
          end else begin
            eb = exp_bits.pop_front();
            check("payload_bit", 32'(bit_o), 32'(eb));
          end
        end
        if (done_o) begin
          n_done++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done_o=1 expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("crc_calc", 32'(crc_calc_o), 32'(e.calc));
            check("crc_rcvd", 32'(crc_rcvd_o), 32'(e.rcvd));
            check("crc_err", 32'(crc_err_o), 32'(e.cerr));
            check("end_err", 32'(end_err_o), 32'(e.eerr));
            check("timeout", 32'(timeout_o), 32'(e.to));
            check("bit_count", 32'(bv_cnt), 32'(e.nbits));
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_i     = 1'b1;
    start_i   = 1'b0;
    len_i     = '0;
    timeout_i = '0;
    abort_i   = 1'b0;
    sample_i  = 1'b0;
    data_i    = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_bit", 32'(bit_o), 32'd0);
    check("rst_bit_valid", 32'(bit_valid_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_flags", 32'({crc_err_o, end_err_o, timeout_o}), 32'd0);
    check("rst_crc_calc", 32'(crc_calc_o), 32'd0);
    check("rst_crc_rcvd", 32'(crc_rcvd_o), 32'd0);

    // Sample strobes while idle must do nothing.
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 1);
    check("idle_sample_busy", 32'(busy_o), 32'd0);

    // 1: 4096 ones, correct CRC 0x7FA1, good end bit.
    run_block(4096, 8'hFF, 16'h7FA1, 1'b1, 0, 16'h7FA1, 1'b0, -1, 1'b0);
    // 2: wrong card CRC.
    run_block(4096, 8'hFF, 16'h7FA0, 1'b1, 0, 16'h7FA1, 1'b1, -1, 1'b0);
    repeat (4) tick();
    check("crc_err_sticky", 32'(crc_err_o), 32'd1);
    check("crc_rcvd_hold", 32'(crc_rcvd_o), 32'h7FA0);
    // 3: bad end bit.
    run_block(4096, 8'hFF, 16'h7FA1, 1'b0, 0, 16'h7FA1, 1'b0, -1, 1'b0);

    // 4: timeout after the 8th idle strobe; flags/CRC cleared by the new start.
    e.calc = 16'h0; e.rcvd = 16'h0; e.cerr = 1'b0; e.eerr = 1'b0; e.to = 1'b1; e.nbits = 0;
    exp_q.push_back(e);
    len_i     = 13'd16;
    timeout_i = 16'd8;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      sample_i = 1'b1;
      data_i   = 1'b1;
      tick();
      sample_i = 1'b0;
      if (k < 8) check("to_no_early_done", 32'(done_o), 32'd0);
      else       check("to_done_after_8th", 32'(done_o), 32'd1);
      tick();
    end
    check("to_idle", 32'(busy_o), 32'd0);
    repeat (3) tick();

    // 5: abort after 100 payload bits, then a clean block.
    run_block(4096, 8'hFF, 16'h7FA1, 1'b1, 0, 16'h7FA1, 1'b0, 100, 1'b0);
    repeat (5) tick();
    check("abort_no_done", 32'(n_done), 32'd4);
    run_block(4096, 8'hFF, 16'h7FA1, 1'b1, 0, 16'h7FA1, 1'b0, -1, 1'b0);

    // 6: 0xA5, sparse strobes, start_i pulsed mid-block; CRC16 of 0xA5 = 0xE54F.
    run_block(8, 8'hA5, 16'hE54F, 1'b1, 2, 16'hE54F, 1'b0, -1, 1'b1);

    // Empty payload: start + CRC 0x0000 + end bit.
    run_block(0, 8'h00, 16'h0000, 1'b1, 1, 16'h0000, 1'b0, -1, 1'b0);

    repeat (5) tick();
    check("exp_results_drained", 32'(exp_q.size()), 32'd0);
    check("exp_bits_drained", 32'(exp_bits.size()), 32'd0);
    check("done_count", 32'(n_done), 32'd7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
